// File: rtl/pim_seq_ctrl.sv
// pim_seq_ctrl -- command sequencer for a processing-in-memory array.
//
// Accepts one command at a time (write row, read row, bit-serial MAC,
// reserved no-op) and drives the PIM macro, then returns one response.
// MAC activations are issued LSB plane first on pim_rwl, one plane per cycle.
//
// Optional build macro:
//   PIM_SEQ_CTRL_EARLY_TERM_EN  stop issuing planes once all remaining
//                               activation bits are zero (>= 1 plane issued)
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only in IDLE)
//   cmd_op                             00 write, 01 read, 10 MAC, 11 reserved
//   cmd_addr, cmd_wdata, cmd_act       row address, write data, activations
//   rsp_valid/rsp_ready, rsp_data      response handshake and data
//   pim_d, pim_addr, pim_rwl           PIM write data, address, RWL bit plane
//   pim_w_en, pim_p_en                 PIM write / processing enables
//   pim_q, pim_mac_out                 PIM registered read data / MAC result
module pim_seq_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int PWIDTH = 32,
    parameter int PDEPTH = 1 << AWIDTH,
    parameter int IWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [AWIDTH-1:0]        cmd_addr,
    input  logic [PWIDTH-1:0]        cmd_wdata,
    input  logic [PDEPTH*IWIDTH-1:0] cmd_act,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DWIDTH-1:0]        rsp_data,
    output logic [PWIDTH-1:0]        pim_d,
    output logic [AWIDTH-1:0]        pim_addr,
    output logic [PDEPTH-1:0]        pim_rwl,
    output logic                     pim_w_en,
    output logic                     pim_p_en,
    input  logic [PWIDTH-1:0]        pim_q,
    input  logic [DWIDTH-1:0]        pim_mac_out
);

    localparam int KW = $clog2(IWIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_READ_CAP, S_COMPUTE, S_DRAIN, S_CAPTURE, S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_MAC   = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    state_t                         state_q, state_nx;
    // Remaining (not yet issued) activation bits, shifted right per plane,
    // so bit 0 of each word is always the next plane to issue.
    logic [PDEPTH-1:0][IWIDTH-1:0]  act_q, act_nx;
    logic [KW-1:0]                  k_q, k_nx;
    logic                           planes_done;

    logic [PWIDTH-1:0]              pim_d_nx;
    logic [AWIDTH-1:0]              pim_addr_nx;
    logic [PDEPTH-1:0]              pim_rwl_nx;
    logic                           pim_w_en_nx;
    logic                           pim_p_en_nx;
    logic                           rsp_valid_nx;
    logic [DWIDTH-1:0]              rsp_data_nx;

    // Held low during reset so no command is taken while rst_n is asserted.
    assign cmd_ready = rst_n && (state_q == S_IDLE);

    // k_q counts planes already issued; the current plane is the last one
    // once it reaches IWIDTH.
`ifdef PIM_SEQ_CTRL_EARLY_TERM_EN
    assign planes_done = (k_q == KW'(IWIDTH)) || (act_q == '0);
`else
    assign planes_done = (k_q == KW'(IWIDTH));
`endif

    // All pim_*/rsp_* outputs are registered, so the next-state logic also
    // computes their values for the state being entered. pim_addr and pim_d
    // double as the latched command address and write data; the state
    // itself records the latched op.
    always_comb begin
        state_nx     = state_q;
        act_nx       = act_q;
        k_nx         = k_q;
        pim_d_nx     = pim_d;
        pim_addr_nx  = pim_addr;
        pim_rwl_nx   = '0;
        pim_w_en_nx  = 1'b0;
        pim_p_en_nx  = 1'b0;
        rsp_valid_nx = rsp_valid;
        rsp_data_nx  = rsp_data;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pim_addr_nx = cmd_addr;
                    pim_d_nx    = cmd_wdata;
                    act_nx      = cmd_act;
                    k_nx        = '0;
                    case (cmd_op)
                        OP_WRITE: begin
                            state_nx    = S_WRITE;
                            pim_w_en_nx = 1'b1;
                        end
                        OP_READ: begin
                            state_nx = S_READ;
                        end
                        OP_MAC: begin
                            state_nx    = S_COMPUTE;
                            pim_p_en_nx = 1'b1;
                            k_nx        = KW'(1);
                            for (int unsigned j = 0; j < PDEPTH; j++) begin
                                pim_rwl_nx[j] = cmd_act[j*IWIDTH];
                                act_nx[j]     = cmd_act[j*IWIDTH +: IWIDTH] >> 1;
                            end
                        end
                        default: begin
                            state_nx     = S_RESP;
                            rsp_valid_nx = 1'b1;
                            rsp_data_nx  = '0;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                state_nx     = S_RESP;
                rsp_valid_nx = 1'b1;
                rsp_data_nx  = '0;
            end
            S_READ: begin
                state_nx = S_READ_CAP;
            end
            S_READ_CAP: begin
                state_nx     = S_RESP;
                rsp_valid_nx = 1'b1;
                rsp_data_nx  = DWIDTH'(pim_q);
            end
            S_COMPUTE: begin
                if (planes_done) begin
                    state_nx = S_DRAIN;
                    k_nx     = '0;
                end else begin
                    pim_p_en_nx = 1'b1;
                    k_nx        = k_q + KW'(1);
                    for (int unsigned j = 0; j < PDEPTH; j++) begin
                        pim_rwl_nx[j] = act_q[j][0];
                        act_nx[j]     = act_q[j] >> 1;
                    end
                end
            end
            S_DRAIN: begin
                state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nx     = S_RESP;
                rsp_valid_nx = 1'b1;
                rsp_data_nx  = pim_mac_out;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nx     = S_IDLE;
                    rsp_valid_nx = 1'b0;
                end
            end
            default: begin
                state_nx     = S_IDLE;
                rsp_valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            act_q     <= '0;
            k_q       <= '0;
            pim_d     <= '0;
            pim_addr  <= '0;
            pim_rwl   <= '0;
            pim_w_en  <= 1'b0;
            pim_p_en  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_nx;
            act_q     <= act_nx;
            k_q       <= k_nx;
            pim_d     <= pim_d_nx;
            pim_addr  <= pim_addr_nx;
            pim_rwl   <= pim_rwl_nx;
            pim_w_en  <= pim_w_en_nx;
            pim_p_en  <= pim_p_en_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
        end
    end

endmodule

// File: tb/tb_pim_seq_ctrl.sv
// Testbench for pim_seq_ctrl with a small behavioural PIM array model.
module tb_pim_seq_ctrl;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int PW = 32;
    localparam int PD = 4;
    localparam int IW = 8;

    localparam logic [1:0] WR = 2'b00, RD = 2'b01, MAC = 2'b10, RSV = 2'b11;

`ifdef PIM_SEQ_CTRL_EARLY_TERM_EN
    localparam int MAC52_LAT = 6,  MAC52_PC = 3;
    localparam int ZERO_LAT  = 4,  ZERO_PC  = 1;
`else
    localparam int MAC52_LAT = 11, MAC52_PC = 8;
    localparam int ZERO_LAT  = 11, ZERO_PC  = 8;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [AW-1:0]     cmd_addr = '0;
    logic [PW-1:0]     cmd_wdata = '0;
    logic [PD*IW-1:0]  cmd_act = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DW-1:0]     rsp_data;
    logic [PW-1:0]     pim_d;
    logic [AW-1:0]     pim_addr;
    logic [PD-1:0]     pim_rwl;
    logic              pim_w_en;
    logic              pim_p_en;
    logic [PW-1:0]     pim_q;
    logic [DW-1:0]     pim_mac_out;

    always #5 clk = ~clk;

    pim_seq_ctrl #(
        .DWIDTH(DW), .AWIDTH(AW), .PWIDTH(PW), .PDEPTH(PD), .IWIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_act(cmd_act),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .pim_d(pim_d), .pim_addr(pim_addr), .pim_rwl(pim_rwl),
        .pim_w_en(pim_w_en), .pim_p_en(pim_p_en),
        .pim_q(pim_q), .pim_mac_out(pim_mac_out)
    );

    // PIM array model: registered read, bit-serial shift-accumulate MAC whose
    // accumulator and shift count clear on any cycle without processing.
    logic [PW-1:0] mem [PD];
    logic [DW-1:0] acc;
    int            shift;
    logic [DW-1:0] dot;

    initial begin
        for (int i = 0; i < PD; i++) mem[i] = '0;
        acc = '0; shift = 0; pim_q = '0; pim_mac_out = '0;
    end

    always_comb begin
        dot = '0;
        for (int j = 0; j < PD; j++)
            if (pim_rwl[j]) dot = dot + DW'(mem[j]);
    end

    always @(posedge clk) begin
        if (pim_w_en) mem[pim_addr] <= pim_d;
        pim_q <= mem[pim_addr];
        if (pim_p_en) begin
            acc         <= acc + (dot << shift);
            pim_mac_out <= acc + (dot << shift);
            shift       <= shift + 1;
        end else begin
            acc   <= '0;
            shift <= 0;
        end
    end

    // Output invariants sampled mid-cycle.
    int viol = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pim_p_en && pim_w_en)        viol <= viol + 1;
            if (!pim_p_en && pim_rwl != '0)  viol <= viol + 1;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [PW-1:0] wd, input logic [PD*IW-1:0] act);
        int t;
        cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_act = act;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [DW-1:0] data, output int pcyc);
        lat = 0; pcyc = 0; data = '0;
        for (int n = 1; n <= 40; n++) begin
            if (rsp_valid) begin
                lat  = n;
                data = rsp_data;
                break;
            end
            if (pim_p_en) pcyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic ack(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_valid_after_ack"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic txn(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [PW-1:0] wd, input logic [PD*IW-1:0] act,
                       input int exp_lat, input logic [DW-1:0] exp_data, input int exp_pc);
        int lat, pc;
        logic [DW-1:0] data;
        issue(op, addr, wd, act);
        wait_rsp(lat, data, pc);
        check({tag, "_lat"},  64'(lat),  64'(exp_lat));
        check({tag, "_data"}, 64'(data), 64'(exp_data));
        check({tag, "_pcyc"}, 64'(pc),   64'(exp_pc));
        ack(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pc, seen;
        logic [DW-1:0] data;

        // Reset state
        #23;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        check("rst_pim_p_en",  64'(pim_p_en),  64'd0);
        check("rst_pim_w_en",  64'(pim_w_en),  64'd0);
        check("rst_pim_rwl",   64'(pim_rwl),   64'd0);
        check("rst_pim_addr",  64'(pim_addr),  64'd0);
        check("rst_pim_d",     64'(pim_d),     64'd0);
        #9 rst_n = 1'b1;
        #1;
        check("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // Writes, reads, reserved op
        txn("wr_row0", WR, 2'd0, 32'h0000_0003, '0, 2, 32'd0, 0);
        txn("wr_row1", WR, 2'd1, 32'h0000_0001, '0, 2, 32'd0, 0);
        txn("wr_row2", WR, 2'd2, 32'h8000_0000, '0, 2, 32'd0, 0);
        txn("rd_row0", RD, 2'd0, '0, '0, 3, 32'h0000_0003, 0);
        txn("rd_row2", RD, 2'd2, '0, '0, 3, 32'h8000_0000, 0);
        txn("rsvd",    RSV, 2'd1, 32'hFFFF_FFFF, '0, 1, 32'd0, 0);

        // MACs: 5*3 + 2*1 = 17; all-zero; 255*3 + 1*1 + 2*2^31 = 766 mod 2^32
        txn("mac_5_2",  MAC, 2'd0, '0, 32'h0000_0205, MAC52_LAT, 32'd17, MAC52_PC);
        txn("mac_zero", MAC, 2'd0, '0, 32'h0000_0000, ZERO_LAT, 32'd0, ZERO_PC);
        txn("mac_wrap", MAC, 2'd0, '0, 32'h0002_01FF, 11, 32'd766, 8);

        // Backpressure: hold response of a read of row 1 with a read of row 0 pending
        issue(RD, 2'd1, '0, '0);
        wait_rsp(lat, data, pc);
        check("hold_lat", 64'(lat), 64'd3);
        cmd_op = RD; cmd_addr = 2'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_data",  64'(rsp_data),  64'd1);
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_hold_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_hold_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(lat, data, pc);
        check("pending_rd_lat",  64'(lat),  64'd3);
        check("pending_rd_data", 64'(data), 64'd3);
        ack("pending_rd");

        // Reset in COMPUTE cycle 4 (act0=0x85, act1=2)
        issue(MAC, 2'd0, '0, 32'h0000_0285);
        check("plane0_rwl",  64'(pim_rwl),  64'b0001);
        check("plane0_p_en", 64'(pim_p_en), 64'd1);
        check("plane0_w_en", 64'(pim_w_en), 64'd0);
        @(posedge clk); #1;
        check("plane1_rwl",  64'(pim_rwl),  64'b0010);
        @(posedge clk); #1;
        check("plane2_rwl",  64'(pim_rwl),  64'b0001);
        @(posedge clk); #1;
        check("plane3_p_en", 64'(pim_p_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_p_en",      64'(pim_p_en),  64'd0);
        check("midrst_rwl",       64'(pim_rwl),   64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("midrst_rel_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check("midrst_no_rsp", 64'(seen), 64'd0);
        txn("mac_after_rst", MAC, 2'd0, '0, 32'h0000_0205, MAC52_LAT, 32'd17, MAC52_PC);

        check("invariants", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
